shift_unit: RTL and testbench

- Parametrised sequential shifter for the CPU datapath; supersedes the fixed left-shift-by-2 used for branch offsets.
- Executes SLL, SRL, SRA and ROTR with a variable shift amount.
- Shifts up to STEP bits per clock over several cycles, trading latency for area.
- Sits beside the ALU and is driven by the control unit through a start/ready/done handshake.

---
 rtl/shift_unit_if.sv | 31 +++
 rtl/shift_unit.sv | 135 +++++++++++++
 tb/tb_shift_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit_if
//  Description : Start/ready/done handshake and operand/result bus between
//                the control unit (master) and the sequential shifter (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_unit_if #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               start;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   in;
    logic               ready;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, op, shamt, in,
        input  ready, done, result
    );

    modport slave (
        input  start, op, shamt, in,
        output ready, done, result
    );
endinterface
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit
//  Description : Multi-cycle shifter (SLL/SRL/SRA/ROTR). Moves at most STEP
//                bits per clock until the requested amount is consumed, then
//                publishes the result with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    shift_unit_if.slave bus
);

    localparam int SHAMT_W = $clog2(WIDTH);

    // STEP <= WIDTH-1 always fits in SHAMT_W bits, so the per-cycle step can
    // be compared directly against the remaining count at its native width.
    localparam logic [SHAMT_W-1:0] c_STEP  = SHAMT_W'(STEP);
    // One extra bit so that WIDTH itself is representable for the rotate
    // complement amount.
    localparam logic [SHAMT_W:0]   c_WIDTH = (SHAMT_W + 1)'(WIDTH);

    localparam logic [1:0] c_OP_SLL  = 2'b00;
    localparam logic [1:0] c_OP_SRL  = 2'b01;
    localparam logic [1:0] c_OP_SRA  = 2'b10;
    localparam logic [1:0] c_OP_ROTR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;

    logic [WIDTH-1:0]   r_work;
    logic [1:0]         r_op;
    logic [SHAMT_W-1:0] r_remaining;
    logic [WIDTH-1:0]   r_result;

    logic [SHAMT_W-1:0] w_k;
    logic [SHAMT_W-1:0] w_remaining_next;
    logic [WIDTH-1:0]   w_shifted;

    // Bits moved this cycle: the full step, or whatever is left if smaller.
    assign w_k              = (r_remaining > c_STEP) ? c_STEP : r_remaining;
    assign w_remaining_next = r_remaining - w_k;

    // One partial shift of the working register by w_k bits.
    always_comb begin
        w_shifted = r_work;
        case (r_op)
            c_OP_SLL:  w_shifted = r_work << w_k;
            c_OP_SRL:  w_shifted = r_work >> w_k;
            c_OP_SRA:  w_shifted = $signed(r_work) >>> w_k;
            c_OP_ROTR: w_shifted = (r_work >> w_k) | (r_work << (c_WIDTH - {1'b0, w_k}));
            default:   w_shifted = r_work;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; a new request is taken in IDLE or DONE.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        bus.ready    = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_remaining_next == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.ready = 1'b1;
                bus.done  = 1'b1;
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept, stepwise shifting while busy, and result
    // publication only on the final step so partial values never show.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work      <= '0;
            r_op        <= c_OP_SLL;
            r_remaining <= '0;
            r_result    <= '0;
        end else if (w_accept) begin
            r_work      <= bus.in;
            r_op        <= bus.op;
            r_remaining <= bus.shamt;
        end else if (r_state == S_BUSY) begin
            r_work      <= w_shifted;
            r_remaining <= w_remaining_next;
            if (w_remaining_next == '0) begin
                r_result <= w_shifted;
            end
        end
    end

    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_unit
//  Description : Directed self-checking bench for shift_unit, with one
//                instance at STEP=1 and one at STEP=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_unit;

    localparam logic [1:0] c_SLL  = 2'b00;
    localparam logic [1:0] c_SRL  = 2'b01;
    localparam logic [1:0] c_SRA  = 2'b10;
    localparam logic [1:0] c_ROTR = 2'b11;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_unit_if #(.WIDTH(32)) bus_s1 ();
    shift_unit_if #(.WIDTH(32)) bus_s3 ();

    shift_unit #(.WIDTH(32), .STEP(1)) u_dut_s1 (
        .clk (clk),
        .rst (rst),
        .bus (bus_s1.slave)
    );

    shift_unit #(.WIDTH(32), .STEP(3)) u_dut_s3 (
        .clk (clk),
        .rst (rst),
        .bus (bus_s3.slave)
    );

    // Shared operand drive; start is steered to the selected instance.
    int          sel;
    logic        start_d;
    logic [1:0]  op_d;
    logic [4:0]  sh_d;
    logic [31:0] in_d;

    assign bus_s1.start = start_d && (sel == 1);
    assign bus_s3.start = start_d && (sel == 3);
    assign bus_s1.op    = op_d;
    assign bus_s3.op    = op_d;
    assign bus_s1.shamt = sh_d;
    assign bus_s3.shamt = sh_d;
    assign bus_s1.in    = in_d;
    assign bus_s3.in    = in_d;

    wire        m_ready  = (sel == 3) ? bus_s3.ready  : bus_s1.ready;
    wire        m_done   = (sel == 3) ? bus_s3.done   : bus_s1.done;
    wire [31:0] m_result = (sel == 3) ? bus_s3.result : bus_s1.result;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called on the negedge right after the accepting edge; returns the
    // number of cycles until done is seen and how many of them had ready=0.
    task automatic wait_done(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        while (m_done !== 1'b1 && lat < 200) begin
            if (m_ready === 1'b0) busy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input int unit, input logic [1:0] op,
                          input logic [4:0] sh, input logic [31:0] din,
                          input logic [31:0] exp, input int n);
        int lat;
        int busy;
        @(negedge clk);
        sel  = unit;
        op_d = op;
        sh_d = sh;
        in_d = din;
        #1;
        check({tag, " ready_before"}, {31'd0, m_ready}, 32'd1);
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        // Disturb operands after accept; the operation must not notice.
        in_d = ~din;
        op_d = ~op;
        sh_d = ~sh;
        wait_done(lat, busy);
        check({tag, " latency"},   lat,      n);
        check({tag, " busy_cyc"},  busy,     n);
        check({tag, " result"},    m_result, exp);
        @(negedge clk);
        check({tag, " done_once"}, {31'd0, m_done}, 32'd0);
        check({tag, " held"},      m_result, exp);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        int busy;
        int dcount;

        rst     = 1'b1;
        start_d = 1'b0;
        sel     = 1;
        op_d    = c_SLL;
        sh_d    = '0;
        in_d    = '0;
        repeat (2) @(negedge clk);
        check("rst s1 ready",  {31'd0, bus_s1.ready}, 32'd1);
        check("rst s1 done",   {31'd0, bus_s1.done},  32'd0);
        check("rst s1 result", bus_s1.result,         32'd0);
        check("rst s3 ready",  {31'd0, bus_s3.ready}, 32'd1);
        check("rst s3 done",   {31'd0, bus_s3.done},  32'd0);
        check("rst s3 result", bus_s3.result,         32'd0);
        rst = 1'b0;

        // STEP=1 instance
        run_op("sll_br",   1, c_SLL,  5'd2,  32'h0000_0001, 32'h0000_0004, 2);
        run_op("sra31",    1, c_SRA,  5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 31);
        run_op("srl31",    1, c_SRL,  5'd31, 32'h8000_0000, 32'h0000_0001, 31);
        run_op("rotr4",    1, c_ROTR, 5'd4,  32'h1234_5678, 32'h8123_4567, 4);
        run_op("z_sll",    1, c_SLL,  5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        run_op("z_srl",    1, c_SRL,  5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        run_op("z_sra",    1, c_SRA,  5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        run_op("z_rotr",   1, c_ROTR, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);

        // STEP=3 instance: k sequence 3,3,2 for shamt 8; exact multiple for 6
        run_op("s3_rotr8", 3, c_ROTR, 5'd8,  32'h1234_5678, 32'h7812_3456, 3);
        run_op("s3_sra7",  3, c_SRA,  5'd7,  32'hF000_0000, 32'hFFE0_0000, 3);
        run_op("s3_sll6",  3, c_SLL,  5'd6,  32'h0000_0003, 32'h0000_00C0, 2);
        run_op("s3_z",     3, c_SRL,  5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);

        // Back-to-back on STEP=1: SLL 0x1 by 1, then SRL 0x80 by 4 from DONE
        @(negedge clk);
        sel  = 1;
        op_d = c_SLL;
        sh_d = 5'd1;
        in_d = 32'h0000_0001;
        #1;
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        check("b2b first busy", {31'd0, m_ready}, 32'd0);
        @(negedge clk);
        check("b2b first done", {31'd0, m_done}, 32'd1);
        check("b2b first res",  m_result,         32'h0000_0002);
        op_d    = c_SRL;
        sh_d    = 5'd4;
        in_d    = 32'h0000_0080;
        start_d = 1'b1;
        @(negedge clk);
        check("b2b no_bubble", {31'd0, m_ready}, 32'd0);
        check("b2b res_kept",  m_result,         32'h0000_0002);
        // A start pulse while busy must be ignored.
        op_d = c_SLL;
        sh_d = 5'd3;
        in_d = 32'h0000_FFFF;
        @(negedge clk);
        start_d = 1'b0;
        wait_done(lat, busy);
        check("b2b second lat", lat,      3);
        check("b2b second res", m_result, 32'h0000_0008);
        @(negedge clk);
        check("b2b idle_after", {31'd0, m_ready}, 32'd1);
        check("b2b no_extra",   {31'd0, m_done},  32'd0);

        // Reset on the 5th busy cycle of SRA by 20
        @(negedge clk);
        sel  = 1;
        op_d = c_SRA;
        sh_d = 5'd20;
        in_d = 32'h8000_0000;
        #1;
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst ready",  {31'd0, m_ready}, 32'd1);
        check("mid_rst done",   {31'd0, m_done},  32'd0);
        check("mid_rst result", m_result,         32'd0);
        rst    = 1'b0;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m_done === 1'b1) dcount++;
        end
        check("mid_rst no_done", dcount, 0);
        run_op("after_rst", 1, c_SRA, 5'd20, 32'h8000_0000, 32'hFFFF_F800, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
